// File: rtl/memoria_dados_param_pkg.sv
// Shared definitions for the parametrised data memory: FSM encoding, counter width, parity.
// Optional parity storage is enabled with the MEMORIA_PARIDADE_EN macro.
package memoria_dados_param_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESPERA  = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    localparam int LARGURA_CONT = 4;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic paridade(input logic [31:0] valor);
        return ^valor;
    endfunction

endpackage

// File: rtl/memoria_dados_array.sv
// Synchronous RAM with write enable and registered read, plus an optional parity bit per word.
// Parity storage and checking exist only when MEMORIA_PARIDADE_EN is defined.
module memoria_dados_array
    import memoria_dados_param_pkg::*;
#(
    parameter int LARGURA_DADO = 8,
    parameter int LARGURA_END  = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    we,
    input  logic [LARGURA_END-1:0]  end_esc,
    input  logic [LARGURA_DADO-1:0] dado_esc,
`ifdef MEMORIA_PARIDADE_EN
    input  logic                    injeta,
    output logic                    erro,
`endif
    input  logic                    re,
    input  logic [LARGURA_END-1:0]  end_le,
    output logic [LARGURA_DADO-1:0] dado_lido
);

`ifdef MEMORIA_PARIDADE_EN
    localparam int LARGURA_PALAVRA = LARGURA_DADO + 1;
`else
    localparam int LARGURA_PALAVRA = LARGURA_DADO;
`endif

    logic [LARGURA_PALAVRA-1:0] mem [2**LARGURA_END];
    logic [LARGURA_PALAVRA-1:0] palavra_esc;
    logic [LARGURA_PALAVRA-1:0] palavra_lida;

`ifdef MEMORIA_PARIDADE_EN
    assign palavra_esc = {paridade(32'(dado_esc)) ^ injeta, dado_esc};
`else
    assign palavra_esc = dado_esc;
`endif

    // A read in the same edge as a write to that word returns the new word.
    assign palavra_lida = (we && (end_esc == end_le)) ? palavra_esc : mem[end_le];

    // NOTE: the storage array has no reset; clearing it would turn the RAM into flops.
    always_ff @(posedge clock) begin
        if (we)
            mem[end_esc] <= palavra_esc;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dado_lido <= '0;
`ifdef MEMORIA_PARIDADE_EN
            erro      <= 1'b0;
`endif
        end else begin
            if (re)
                dado_lido <= palavra_lida[LARGURA_DADO-1:0];
`ifdef MEMORIA_PARIDADE_EN
            erro <= re && (paridade(32'(palavra_lida[LARGURA_DADO-1:0])) != palavra_lida[LARGURA_DADO]);
`endif
        end
    end

endmodule

// File: rtl/memoria_dados_param.sv
// Data memory with configurable wait states and a Pronto/Ocupado handshake.
// Define MEMORIA_PARIDADE_EN to add per-word parity with InjetaErro/ErroParidade ports.
module memoria_dados_param
    import memoria_dados_param_pkg::*;
#(
    parameter int LARGURA_DADO = 8,
    parameter int LARGURA_END  = 8,
    parameter int ESPERAS      = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    EscMem,
    input  logic                    LerMem,
    input  logic [LARGURA_END-1:0]  Endereco,
    input  logic [LARGURA_DADO-1:0] DadoEscrito,
`ifdef MEMORIA_PARIDADE_EN
    input  logic                    InjetaErro,
    output logic                    ErroParidade,
`endif
    output logic [LARGURA_DADO-1:0] DadoLido,
    output logic                    Pronto,
    output logic                    Ocupado
);

    localparam logic [LARGURA_CONT-1:0] CARGA =
        (ESPERAS > 0) ? LARGURA_CONT'(ESPERAS - 1) : '0;

    estado_t                 estado;
    logic [LARGURA_CONT-1:0] cont;
    logic [LARGURA_END-1:0]  end_lat;
    logic                    le_lat;

    logic                    aceita;
    logic                    fim_espera;
    logic                    le_agora;
    logic [LARGURA_END-1:0]  end_le;

    assign aceita     = ((estado == OCIOSO) || (estado == ENTREGA)) && (EscMem || LerMem);
    assign fim_espera = (estado == ESPERA) && (cont == '0);

    // Without wait states the read happens at the acceptance edge; otherwise at the last wait edge.
    assign le_agora = (aceita && LerMem && (ESPERAS == 0)) || (fim_espera && le_lat);
    assign end_le   = (estado == ESPERA) ? end_lat : Endereco;

    // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado  <= OCIOSO;
            cont    <= '0;
            end_lat <= '0;
            le_lat  <= 1'b0;
            Pronto  <= 1'b0;
            Ocupado <= 1'b0;
        end else begin
            Pronto  <= 1'b0;
            Ocupado <= 1'b0;
            case (estado)
                ESPERA: begin
                    if (cont == '0) begin
                        estado <= ENTREGA;
                        Pronto <= 1'b1;
                    end else begin
                        cont    <= cont - LARGURA_CONT'(1);
                        Ocupado <= 1'b1;
                    end
                end
                default: begin
                    if (aceita) begin
                        end_lat <= Endereco;
                        le_lat  <= LerMem;
                        if (ESPERAS == 0) begin
                            estado <= ENTREGA;
                            Pronto <= 1'b1;
                        end else begin
                            estado  <= ESPERA;
                            cont    <= CARGA;
                            Ocupado <= 1'b1;
                        end
                    end else begin
                        estado <= OCIOSO;
                    end
                end
            endcase
        end
    end

    memoria_dados_array #(
        .LARGURA_DADO(LARGURA_DADO),
        .LARGURA_END (LARGURA_END)
    ) u_array (
        .clock    (clock),
        .reset    (reset),
        .we       (aceita && EscMem),
        .end_esc  (Endereco),
        .dado_esc (DadoEscrito),
`ifdef MEMORIA_PARIDADE_EN
        .injeta   (InjetaErro),
        .erro     (ErroParidade),
`endif
        .re       (le_agora),
        .end_le   (end_le),
        .dado_lido(DadoLido)
    );

endmodule

// File: tb/tb_memoria_dados_param.sv
// Self-checking bench: three memory configurations against a transaction-level model.
// Parity checks are compiled in only when MEMORIA_PARIDADE_EN is defined.
module tb_memoria_dados_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        esc  [3] = '{default: 1'b0};
    logic        ler  [3] = '{default: 1'b0};
    logic        inj  [3] = '{default: 1'b0};
    logic [7:0]  endr [3] = '{default: 8'h00};
    logic [15:0] dado [3] = '{default: 16'h0000};

    logic [7:0]  lido0, lido1;
    logic [15:0] lido2;
    logic        pronto [3];
    logic        ocup   [3];
`ifdef MEMORIA_PARIDADE_EN
    logic        err    [3];
`endif

    int n_checks = 0;
    int n_pass   = 0;

    memoria_dados_param #(.LARGURA_DADO(8), .LARGURA_END(8), .ESPERAS(0)) u0 (
        .clock(clk), .reset(rst), .EscMem(esc[0]), .LerMem(ler[0]),
        .Endereco(endr[0]), .DadoEscrito(dado[0][7:0]),
`ifdef MEMORIA_PARIDADE_EN
        .InjetaErro(inj[0]), .ErroParidade(err[0]),
`endif
        .DadoLido(lido0), .Pronto(pronto[0]), .Ocupado(ocup[0]));

    memoria_dados_param #(.LARGURA_DADO(8), .LARGURA_END(8), .ESPERAS(3)) u1 (
        .clock(clk), .reset(rst), .EscMem(esc[1]), .LerMem(ler[1]),
        .Endereco(endr[1]), .DadoEscrito(dado[1][7:0]),
`ifdef MEMORIA_PARIDADE_EN
        .InjetaErro(inj[1]), .ErroParidade(err[1]),
`endif
        .DadoLido(lido1), .Pronto(pronto[1]), .Ocupado(ocup[1]));

    memoria_dados_param #(.LARGURA_DADO(16), .LARGURA_END(4), .ESPERAS(2)) u2 (
        .clock(clk), .reset(rst), .EscMem(esc[2]), .LerMem(ler[2]),
        .Endereco(endr[2][3:0]), .DadoEscrito(dado[2]),
`ifdef MEMORIA_PARIDADE_EN
        .InjetaErro(inj[2]), .ErroParidade(err[2]),
`endif
        .DadoLido(lido2), .Pronto(pronto[2]), .Ocupado(ocup[2]));

    function automatic logic [15:0] lido_of(input int k);
        case (k)
            0:       return {8'h00, lido0};
            1:       return {8'h00, lido1};
            default: return lido2;
        endcase
    endfunction

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nome, got, exp, $time);
    endtask

    // Transaction model: each request completes ESPERAS edges after acceptance.
    int          waits [3] = '{0, 3, 2};
    logic [15:0] dmask [3] = '{16'h00FF, 16'h00FF, 16'hFFFF};
    logic [7:0]  amask [3] = '{8'hFF, 8'hFF, 8'h0F};

    logic [15:0] mem_m [3][256];
    bit          known [3][256];
    bit          bad   [3][256];
    bit          pend  [3] = '{default: 1'b0};
    int          rem   [3] = '{default: 0};
    bit          rd_l  [3] = '{default: 1'b0};
    int          a_l   [3] = '{default: 0};
    bit          exp_pronto [3] = '{default: 1'b0};
    bit          exp_ocup   [3] = '{default: 1'b0};
    bit          exp_err    [3] = '{default: 1'b0};
    logic [15:0] exp_dado   [3] = '{default: 16'h0000};
    bit          dado_ok    [3] = '{default: 1'b1};

    task automatic complete(input int k);
        exp_pronto[k] = 1'b1;
        if (rd_l[k]) begin
            dado_ok[k]  = known[k][a_l[k]];
            exp_dado[k] = mem_m[k][a_l[k]];
            exp_err[k]  = known[k][a_l[k]] && bad[k][a_l[k]];
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                pend[k] = 1'b0; exp_pronto[k] = 1'b0; exp_ocup[k] = 1'b0;
                exp_dado[k] = '0; dado_ok[k] = 1'b1; exp_err[k] = 1'b0;
            end else begin
                int a;
                exp_pronto[k] = 1'b0;
                exp_err[k]    = 1'b0;
                if (pend[k]) begin
                    rem[k]--;
                    if (rem[k] == 0) begin
                        pend[k] = 1'b0;
                        complete(k);
                    end
                end else if (esc[k] || ler[k]) begin
                    a = int'(endr[k] & amask[k]);
                    if (esc[k]) begin
                        mem_m[k][a] = dado[k] & dmask[k];
                        known[k][a] = 1'b1;
                        bad[k][a]   = inj[k];
                    end
                    rd_l[k] = ler[k];
                    a_l[k]  = a;
                    if (waits[k] == 0) complete(k);
                    else begin
                        pend[k] = 1'b1;
                        rem[k]  = waits[k];
                    end
                end
                exp_ocup[k] = pend[k];
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Compare every instance against the model on each falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("u%0d Pronto", k), 32'(pronto[k]), 32'(exp_pronto[k]));
                check($sformatf("u%0d Ocupado", k), 32'(ocup[k]), 32'(exp_ocup[k]));
                if (dado_ok[k]) begin
                    check($sformatf("u%0d DadoLido", k), 32'(lido_of(k)), 32'(exp_dado[k]));
`ifdef MEMORIA_PARIDADE_EN
                    check($sformatf("u%0d ErroParidade", k), 32'(err[k]), 32'(exp_err[k]));
`endif
                end
            end
        end
    end

    task automatic issue(input int k, input bit e, input bit l, input logic [7:0] a,
                         input logic [15:0] d, input bit i);
        esc[k] = e; ler[k] = l; endr[k] = a; dado[k] = d; inj[k] = i;
        @(negedge clk);
        esc[k] = 1'b0; ler[k] = 1'b0; inj[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(2);
        check("reset Pronto", 32'(pronto[0]), 32'd0);
        check("reset Ocupado", 32'(ocup[1]), 32'd0);
        check("reset DadoLido", 32'(lido0), 32'h00);
        rst = 1'b0;

        // ESPERAS=0: write then back-to-back read
        issue(0, 1, 0, 8'h10, 16'h005A, 0);
        check("w0 Pronto", 32'(pronto[0]), 32'd1);
        check("w0 DadoLido held", 32'(lido0), 32'h00);
        issue(0, 0, 1, 8'h10, 16'h0000, 0);
        check("r0 Pronto", 32'(pronto[0]), 32'd1);
        check("r0 DadoLido", 32'(lido0), 32'h5A);
        idle(1);
        check("r0 Pronto drop", 32'(pronto[0]), 32'd0);
        check("r0 DadoLido hold", 32'(lido0), 32'h5A);

        // ESPERAS=3: write, read, dropped request while busy
        issue(1, 1, 0, 8'h10, 16'h005A, 0);
        check("w1 Ocupado", 32'(ocup[1]), 32'd1);
        idle(3);
        check("w1 Pronto", 32'(pronto[1]), 32'd1);
        issue(1, 0, 1, 8'h10, 16'h0000, 0);
        check("r1 Ocupado c1", 32'(ocup[1]), 32'd1);
        issue(1, 0, 1, 8'h20, 16'h0000, 0);
        check("r1 Ocupado c2", 32'(ocup[1]), 32'd1);
        idle(1);
        check("r1 Ocupado c3", 32'(ocup[1]), 32'd1);
        idle(1);
        check("r1 Pronto", 32'(pronto[1]), 32'd1);
        check("r1 DadoLido", 32'(lido1), 32'h5A);
        idle(4);

        // Reset in the middle of a wait
        issue(1, 0, 1, 8'h10, 16'h0000, 0);
        check("r1b Ocupado", 32'(ocup[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async Ocupado", 32'(ocup[1]), 32'd0);
        check("async Pronto", 32'(pronto[1]), 32'd0);
        check("async DadoLido", 32'(lido1), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        issue(1, 0, 1, 8'h10, 16'h0000, 0);
        idle(3);
        check("post-reset Pronto", 32'(pronto[1]), 32'd1);
        check("post-reset DadoLido", 32'(lido1), 32'h5A);

        // Simultaneous write and read
        issue(0, 1, 1, 8'hFF, 16'h00C3, 0);
        check("wr Pronto", 32'(pronto[0]), 32'd1);
        check("wr DadoLido", 32'(lido0), 32'hC3);
        issue(0, 0, 1, 8'hFF, 16'h0000, 0);
        check("wr reread", 32'(lido0), 32'hC3);

        // 16-bit data, 4-bit address
        issue(2, 0, 1, 8'h00, 16'h0000, 0);
        idle(2);
        check("u2 unwritten Pronto", 32'(pronto[2]), 32'd1);
        check("u2 unwritten Ocupado", 32'(ocup[2]), 32'd0);
        idle(1);
        issue(2, 1, 0, 8'h0F, 16'hBEEF, 0);
        idle(2);
        issue(2, 0, 1, 8'h0F, 16'h0000, 0);
        idle(2);
        check("u2 Pronto", 32'(pronto[2]), 32'd1);
        check("u2 DadoLido", 32'(lido2), 32'hBEEF);

`ifdef MEMORIA_PARIDADE_EN
        issue(0, 1, 0, 8'h30, 16'h0001, 1);
        check("par w err", 32'(err[0]), 32'd0);
        issue(0, 0, 1, 8'h30, 16'h0000, 0);
        check("par injected", 32'(err[0]), 32'd1);
        issue(0, 1, 0, 8'h30, 16'h0001, 0);
        issue(0, 0, 1, 8'h30, 16'h0000, 0);
        check("par clean", 32'(err[0]), 32'd0);
        check("par DadoLido", 32'(lido0), 32'h01);
`endif

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
